// File: rtl/pe_window_pkg.sv
// Shared types, constants and span helpers for the per-pixel window generator.
// PE_WIN_WRAP_EN: when defined, spans with start > end wrap around the line/frame edge.
package pe_window_pkg;

  localparam int H_VISIBLE   = 240;
  localparam int V_TOTAL     = 228;
  localparam int HCOUNT_W    = 9;
  localparam int VCOUNT_W    = 8;
  localparam int COORD_W     = 8;
  localparam int WINREG_W    = 2 * COORD_W;
  localparam int DISPCNT_W   = 16;
  localparam int NUM_WIN     = 2;
  localparam int WIN0_EN_BIT = 13;
  localparam int OBJ_EN_BIT  = 15;

`ifdef PE_WIN_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic {
    OUTSIDE = 1'b0,
    INSIDE  = 1'b1
  } win_state_e;

  // lo is the inclusive start ([15:8]), hi the exclusive end ([7:0]).
  typedef struct packed {
    logic [COORD_W-1:0] lo;
    logic [COORD_W-1:0] hi;
  } win_span_t;

  function automatic logic span_contains(input win_span_t span,
                                         input logic [COORD_W-1:0] pos);
    logic hit;
    hit = 1'b0;
    if (span.lo < span.hi) begin
      hit = (pos >= span.lo) && (pos < span.hi);
    end else if (span.lo > span.hi) begin
      hit = WRAP_EN && ((pos >= span.lo) || (pos < span.hi));
    end
    return hit;
  endfunction

  function automatic win_state_e span_init_state(input win_span_t span);
    return (WRAP_EN && (span.lo > span.hi)) ? INSIDE : OUTSIDE;
  endfunction

  // Without wrap support an inverted span must never open horizontally.
  function automatic logic span_h_allowed(input win_span_t span);
    return WRAP_EN || (span.lo <= span.hi);
  endfunction

endpackage

// File: rtl/pe_window_axis.sv
// One window's line-latched coordinates, vertical flag and horizontal tracker.
// Wrap-around behaviour follows PE_WIN_WRAP_EN through the package helpers.
module pe_window_axis
  import pe_window_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                line_start,
  input  logic                pixel_valid,
  input  logic [HCOUNT_W-1:0] hcount,
  input  logic [VCOUNT_W-1:0] vcount,
  input  win_span_t           winh,
  input  win_span_t           winv,
  output logic                vin,
  output logic                hin
);

  win_span_t           h_shadow_reg, h_eff;
  win_span_t           v_shadow_reg, v_eff;
  logic [VCOUNT_W-1:0] vline_reg, vline_eff;
  win_state_e          state_reg, state_eff, state_next;
  logic                hit_x1, hit_x2;

  // A line_start in this cycle takes effect before the coincident pixel is judged.
  always_comb begin
    h_eff     = h_shadow_reg;
    v_eff     = v_shadow_reg;
    vline_eff = vline_reg;
    state_eff = state_reg;
    if (line_start) begin
      h_eff     = winh;
      v_eff     = winv;
      vline_eff = vcount;
      state_eff = span_init_state(winh);
    end
  end

  always_comb begin
    hit_x1     = (hcount == {1'b0, h_eff.lo});
    hit_x2     = (hcount == {1'b0, h_eff.hi});
    vin        = span_contains(v_eff, vline_eff);
    hin        = span_h_allowed(h_eff) && ((state_eff == INSIDE) || hit_x1) && !hit_x2;
    state_next = state_eff;
    if (pixel_valid) begin
      state_next = hin ? INSIDE : OUTSIDE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_shadow_reg <= '0;
      v_shadow_reg <= '0;
      vline_reg    <= '0;
      state_reg    <= OUTSIDE;
    end else begin
      h_shadow_reg <= h_eff;
      v_shadow_reg <= v_eff;
      vline_reg    <= vline_eff;
      state_reg    <= state_next;
    end
  end

endmodule

// File: rtl/pe_window_gen.sv
// Per-pixel WIN0/WIN1/OBJ window membership flags, registered one cycle after the pixel.
// PE_WIN_WRAP_EN: enables wrap-around windows (start coordinate > end coordinate).
module pe_window_gen
  import pe_window_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 line_start,
  input  logic                 pixel_valid,
  input  logic [HCOUNT_W-1:0]  hcount,
  input  logic [VCOUNT_W-1:0]  vcount,
  input  logic [WINREG_W-1:0]  win0h,
  input  logic [WINREG_W-1:0]  win1h,
  input  logic [WINREG_W-1:0]  win0v,
  input  logic [WINREG_W-1:0]  win1v,
  input  logic [DISPCNT_W-1:0] dispcnt,
  input  logic                 obj_win_in,
  output logic                 win0,
  output logic                 win1,
  output logic                 obj,
  output logic                 out_valid
);

  logic [WINREG_W-1:0] winh_arr [NUM_WIN];
  logic [WINREG_W-1:0] winv_arr [NUM_WIN];
  logic [NUM_WIN-1:0]  vin_vec;
  logic [NUM_WIN-1:0]  hin_vec;
  logic [NUM_WIN-1:0]  win_next;
  logic [NUM_WIN-1:0]  win_reg;
  logic                obj_next;
  logic                obj_reg;
  logic                out_valid_reg;
  logic                unused_dispcnt;

  assign winh_arr[0] = win0h;
  assign winh_arr[1] = win1h;
  assign winv_arr[0] = win0v;
  assign winv_arr[1] = win1v;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WIN; gi++) begin : g_win
      pe_window_axis u_axis (
        .clock       (clock),
        .reset       (reset),
        .line_start  (line_start),
        .pixel_valid (pixel_valid),
        .hcount      (hcount),
        .vcount      (vcount),
        .winh        (winh_arr[gi]),
        .winv        (winv_arr[gi]),
        .vin         (vin_vec[gi]),
        .hin         (hin_vec[gi])
      );

      // Enables come straight from dispcnt in the pixel's own cycle.
      assign win_next[gi] = pixel_valid & dispcnt[WIN0_EN_BIT + gi] & vin_vec[gi] & hin_vec[gi];
    end
  endgenerate

  assign obj_next       = pixel_valid & dispcnt[OBJ_EN_BIT] & obj_win_in;
  assign unused_dispcnt = ^dispcnt[WIN0_EN_BIT-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      win_reg       <= '0;
      obj_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      win_reg       <= win_next;
      obj_reg       <= obj_next;
      out_valid_reg <= pixel_valid;
    end
  end

  assign win0      = win_reg[0];
  assign win1      = win_reg[1];
  assign obj       = obj_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_pe_window_gen.sv
// Randomised + directed bench for pe_window_gen against a range-based scanline model.
// Expectations follow PE_WIN_WRAP_EN when the bench is built with it defined.
module tb_pe_window_gen;

`ifdef PE_WIN_WRAP_EN
  localparam bit TB_WRAP = 1'b1;
`else
  localparam bit TB_WRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, line_start, pixel_valid, obj_win_in;
  logic [8:0]  hcount;
  logic [7:0]  vcount;
  logic [15:0] win0h, win1h, win0v, win1v, dispcnt;
  logic        win0, win1, obj, out_valid;

  always #5 clk = ~clk;

  pe_window_gen dut (
    .clock       (clk),
    .reset       (reset),
    .line_start  (line_start),
    .pixel_valid (pixel_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .win0h       (win0h),
    .win1h       (win1h),
    .win0v       (win0v),
    .win1v       (win1v),
    .dispcnt     (dispcnt),
    .obj_win_in  (obj_win_in),
    .win0        (win0),
    .win1        (win1),
    .obj         (obj),
    .out_valid   (out_valid)
  );

  int checks   = 0;
  int failures = 0;

  // Model state: coordinates and vertical decision latched per scanline.
  logic [15:0] m_h [2];
  logic        m_vin [2];
  int          line_id = 0;
  logic        exp_valid, exp_w0, exp_w1, exp_obj;
  int          exp_hc, exp_line;

  int dut_cnt0 [64];
  int dut_cnt1 [64];
  int dut_cnto [64];
  int mdl_cnt0 [64];
  int mdl_cnt1 [64];
  int first0   [64];
  int last0    [64];
  bit obj_all_ones = 1'b0;

  // Membership of pos in [start, end) with optional wrap.
  function automatic bit in_span(input logic [15:0] r, input int pos);
    int s, e;
    s = int'(r[15:8]);
    e = int'(r[7:0]);
    if (s < e)  return (pos >= s) && (pos < e);
    if (s == e) return 1'b0;
    return TB_WRAP && ((pos >= s) || (pos < e));
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_h[i]   = '0;
        m_vin[i] = 1'b0;
      end
      exp_valid = 1'b0;
      exp_w0    = 1'b0;
      exp_w1    = 1'b0;
      exp_obj   = 1'b0;
    end else begin
      if (line_start) begin
        line_id++;
        m_h[0]   = win0h;
        m_h[1]   = win1h;
        m_vin[0] = in_span(win0v, int'(vcount));
        m_vin[1] = in_span(win1v, int'(vcount));
      end
      exp_valid = pixel_valid;
      exp_w0    = pixel_valid && dispcnt[13] && m_vin[0] && in_span(m_h[0], int'(hcount));
      exp_w1    = pixel_valid && dispcnt[14] && m_vin[1] && in_span(m_h[1], int'(hcount));
      exp_obj   = pixel_valid && dispcnt[15] && obj_win_in;
    end
    exp_hc   = int'(hcount);
    exp_line = line_id % 64;
  endtask

  task automatic chk(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s line=%0d hcount=%0d dut=%b expected=%b", name, exp_line, exp_hc, act, expv);
    end
  endtask

  task automatic lit(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s dut=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic compare_step();
    chk("out_valid", out_valid, exp_valid);
    chk("win0", win0, exp_w0);
    chk("win1", win1, exp_w1);
    chk("obj", obj, exp_obj);
    if (out_valid === 1'b1 && win0 === 1'b1) begin
      dut_cnt0[exp_line]++;
      if (exp_hc < first0[exp_line]) first0[exp_line] = exp_hc;
      last0[exp_line] = exp_hc;
    end
    if (out_valid === 1'b1 && win1 === 1'b1) dut_cnt1[exp_line]++;
    if (out_valid === 1'b1 && obj === 1'b1)  dut_cnto[exp_line]++;
    if (exp_w0) mdl_cnt0[exp_line]++;
    if (exp_w1) mdl_cnt1[exp_line]++;
  endtask

  // Advance one clock: model sees the same inputs the DUT samples, compare after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_step();
  endtask

  function automatic logic [15:0] rand_span();
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 239));
    b = 8'($urandom_range(0, 239));
    case ($urandom_range(0, 5))
      0: return 16'($urandom);
      1: return (a < b) ? {a, b} : {b, a};
      2: return {a, a};
      3: return (a > b) ? {a, b} : {b, a};
      4: return {a, 8'($urandom_range(240, 255))};
      default: return (a < b) ? {a, b} : {b, a};
    endcase
  endfunction

  task automatic run_line(input logic [7:0] vc, input bit ls_on_pixel, input int chg_at,
                          input logic [15:0] chg_w0h, input int rst_at, input bit rnd,
                          output int lid);
    vcount = vc;
    if (!ls_on_pixel) begin
      line_start  = 1'b1;
      pixel_valid = 1'b0;
      hcount      = 9'($urandom);
      step();
      line_start = 1'b0;
    end
    for (int h = 0; h < 240; h++) begin
      while (rnd && $urandom_range(0, 7) == 0) begin
        pixel_valid = 1'b0;
        line_start  = 1'b0;
        hcount      = 9'($urandom);
        obj_win_in  = 1'($urandom);
        step();
      end
      line_start  = (h == 0) && ls_on_pixel;
      pixel_valid = 1'b1;
      hcount      = 9'(h);
      obj_win_in  = obj_all_ones ? 1'b1 : 1'($urandom);
      reset       = (h == rst_at);
      if (h == chg_at) win0h = chg_w0h;
      if (rnd && $urandom_range(0, 63) == 0) begin
        win0h   = rand_span();
        win1h   = rand_span();
        win0v   = rand_span();
        win1v   = rand_span();
        dispcnt = 16'($urandom);
      end
      step();
      reset = 1'b0;
    end
    line_start  = 1'b0;
    pixel_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    lid = line_id % 64;
    $display("line id=%0d vcount=%0d win0_px=%0d win1_px=%0d obj_px=%0d", lid, vc,
             dut_cnt0[lid], dut_cnt1[lid], dut_cnto[lid]);
  endtask

  int lid;

  initial begin
    for (int i = 0; i < 64; i++) begin
      dut_cnt0[i] = 0; dut_cnt1[i] = 0; dut_cnto[i] = 0;
      mdl_cnt0[i] = 0; mdl_cnt1[i] = 0;
      first0[i]   = 999; last0[i] = -1;
    end
    reset = 1'b1; line_start = 1'b0; pixel_valid = 1'b0; obj_win_in = 1'b0;
    hcount = '0; vcount = '0;
    win0h = 16'h1050; win0v = 16'h2040; win1h = '0; win1v = '0; dispcnt = 16'h2000;
    // Pixels presented during reset must not produce flags.
    pixel_valid = 1'b1; obj_win_in = 1'b1; dispcnt = 16'hE000;
    for (int i = 0; i < 3; i++) step();
    lit("reset_out_valid", int'(out_valid), 0);
    reset = 1'b0; pixel_valid = 1'b0; obj_win_in = 1'b0; dispcnt = 16'h2000;
    step();

    // Basic window, line inside vertical range.
    run_line(8'h30, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("basic_count", dut_cnt0[lid], 64);
    lit("basic_model_count", mdl_cnt0[lid], 64);
    lit("basic_first", first0[lid], 16'h10);
    lit("basic_last", last0[lid], 16'h4F);

    // Y2 is exclusive; line_start coincident with the first pixel.
    run_line(8'h40, 1'b1, -1, 16'h0, -1, 1'b0, lid);
    lit("y2_exclusive", dut_cnt0[lid], 0);
    run_line(8'h20, 1'b1, -1, 16'h0, -1, 1'b0, lid);
    lit("y1_inclusive", dut_cnt0[lid], 64);

    // Inverted horizontal span on WIN1.
    win1h = 16'hC820; win1v = 16'h00E4; dispcnt = 16'h4000;
    run_line(8'h10, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("wrap_win1", dut_cnt1[lid], TB_WRAP ? 72 : 0);
    lit("wrap_model", mdl_cnt1[lid], TB_WRAP ? 72 : 0);

    // Mid-line register write only lands on the next line.
    dispcnt = 16'h2000; win0h = 16'h1050;
    run_line(8'h30, 1'b0, 16'h30, 16'h0010, -1, 1'b0, lid);
    lit("midline_current", dut_cnt0[lid], 64);
    run_line(8'h30, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("midline_next", dut_cnt0[lid], 16);
    lit("midline_next_first", first0[lid], 0);
    lit("midline_next_last", last0[lid], 16'h0F);

    // X1 == X2 empty; OBJ flag gating.
    win0h = 16'h3030; obj_all_ones = 1'b1; dispcnt = 16'h2000;
    run_line(8'h30, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("x1_eq_x2", dut_cnt0[lid], 0);
    lit("obj_disabled", dut_cnto[lid], 0);
    dispcnt = 16'h8000;
    run_line(8'h30, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("obj_enabled", dut_cnto[lid], 240);
    obj_all_ones = 1'b0;

    // Reset mid-window, then recovery on the next line_start.
    win0h = 16'h1050; dispcnt = 16'h2000;
    run_line(8'h30, 1'b0, -1, 16'h0, 16'h20, 1'b0, lid);
    lit("reset_midline", dut_cnt0[lid], 16);
    lit("reset_midline_last", last0[lid], 16'h1F);
    run_line(8'h30, 1'b0, -1, 16'h0, -1, 1'b0, lid);
    lit("after_reset", dut_cnt0[lid], 64);

    // Randomised scanlines against the model.
    for (int n = 0; n < 30; n++) begin
      win0h = rand_span(); win1h = rand_span();
      win0v = rand_span(); win1v = rand_span();
      dispcnt = 16'($urandom);
      run_line(8'($urandom_range(0, 227)), 1'($urandom), -1, 16'h0, -1, 1'b1, lid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
